// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, instruction width,
// PC step size and a misalignment helper.
package core_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    // Fetch FSM: BOOT lets memory settle for one cycle, RUN streams, TRAP is terminal.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } fetch_state_e;

    // Redirect targets must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, instr} entries toward decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, in_data   write request and payload (ignored when full without pop)
//   pop             read request (ignored when empty)
//   flush           empties the FIFO, overrides push and pop
//   full, empty     occupancy flags (decoded from the count register)
//   head_data       payload of the oldest entry (registered storage, no bypass)
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and count; flush wins over everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, captures the
// same-cycle instruction word and queues {pc, instr} pairs toward decode.
// Handles redirects with a flush and traps on misaligned redirect targets.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_addr / imem_data        byte address out (= pc_q), instruction word in
//   redirect_valid / redirect_pc PC change request and target
//   out_valid/out_ready          handshake toward decode
//   out_instr/out_pc             head entry of the fetch buffer
//   trap / trap_pc               sticky misaligned-redirect trap and offending target
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               trap,
    output logic [XLEN-1:0]    trap_pc
);

    localparam int unsigned ENTRY_W = XLEN + INSTR_W;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             trap_q, trap_d;
    logic [XLEN-1:0]  trap_pc_q, trap_pc_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic             pop_req;

    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_head[ENTRY_W-1:INSTR_W];
    assign out_instr = fifo_head[INSTR_W-1:0];
    assign trap      = trap_q;
    assign trap_pc   = trap_pc_q;
    assign pop_req   = out_valid && out_ready;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .in_data   ({pc_q, imem_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    // Next-state, next-PC mux and FIFO control; redirect outranks pop/push.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        trap_d     = trap_q;
        trap_pc_d  = trap_pc_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                // Single settle cycle; an early redirect still takes effect.
                state_d = ST_RUN;
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    if (is_misaligned(redirect_pc[1:0])) begin
                        trap_d    = 1'b1;
                        trap_pc_d = redirect_pc;
                        state_d   = ST_TRAP;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    if (is_misaligned(redirect_pc[1:0])) begin
                        trap_d    = 1'b1;
                        trap_pc_d = redirect_pc;
                        state_d   = ST_TRAP;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    fifo_pop = pop_req;
                    // A pop in the same cycle frees the slot for this push.
                    if (!fifo_full || pop_req) begin
                        fifo_push = 1'b1;
                        pc_d      = pc_q + XLEN'(PC_STEP);
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/trap checks plus a scoreboard that
// expects, after every reset or aligned redirect, the sequential word stream
// starting at the target, each paired with the memory contents at that address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        trap;
    logic [31:0] trap_pc;

    logic [31:0] w_imem_addr, w_imem_data;
    logic        w_out_valid;
    logic [31:0] w_out_instr, w_out_pc;
    logic        w_trap;
    logic [31:0] w_trap_pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the word index.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return ((addr >> 2) * 32'h9E37_79B1) ^ 32'hA5A5_0013;
    endfunction

    assign imem_data   = mem_word(imem_addr);
    assign w_imem_data = mem_word(w_imem_addr);

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .trap           (trap),
        .trap_pc        (trap_pc)
    );

    // Second instance exercising PC wrap from the top of the address space.
    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (w_imem_addr),
        .imem_data      (w_imem_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (w_out_valid),
        .out_ready      (1'b1),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .trap           (w_trap),
        .trap_pc        (w_trap_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode stream after a restart: consecutive words from the target.
    task automatic start_stream(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back('{pc: p, instr: mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        start_stream(32'h0);
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        if (target[1:0] == 2'b00) start_stream(target);
        else exp_q.delete();
        tick();
        redirect_valid = 1'b0;
    endtask

    // Scoreboard monitor: every accepted head must be the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got pc 0x%08h, no entry expected", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("stream_pc", out_pc, e.pc);
                check("stream_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        int since;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset, BOOT cycle and first-instruction latency; wrap instance too.
        do_reset(3);
        @(negedge clk);
        check("boot_valid", 32'(out_valid), 32'h0);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_trap", 32'(trap), 32'h0);
        check("reset_trap_pc", trap_pc, 32'h0);
        check("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("run_empty_valid", 32'(out_valid), 32'h0);
        tick();
        @(negedge clk);
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_pc", out_pc, 32'h0);
        check("wrap_first_pc", w_out_pc, 32'hFFFF_FFFC);
        check("wrap_first_instr", w_out_instr, mem_word(32'hFFFF_FFFC));
        tick();
        @(negedge clk);
        check("wrap_second_pc", w_out_pc, 32'h0);
        check("wrap_second_instr", w_out_instr, mem_word(32'h0));
        check("wrap_trap", 32'(w_trap), 32'h0);
        repeat (20) tick();

        // Back-pressure from reset: buffer fills to two, address freezes at 0x8.
        out_ready = 1'b0;
        do_reset(2);
        repeat (6) tick();
        @(negedge clk);
        check("stall_addr", imem_addr, 32'h8);
        check("stall_valid", 32'(out_valid), 32'h1);
        check("stall_head_pc", out_pc, 32'h0);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();

        // Redirect while the buffer holds two entries.
        out_ready = 1'b0;
        repeat (3) tick();
        redirect(32'h40);
        @(negedge clk);
        check("redir_flush_valid", 32'(out_valid), 32'h0);
        tick();
        @(negedge clk);
        check("redir_valid", 32'(out_valid), 32'h1);
        check("redir_pc", out_pc, 32'h40);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();

        // Redirect coincident with a pop on a full buffer: flush wins.
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        redirect(32'h100);
        @(negedge clk);
        check("pop_redir_valid", 32'(out_valid), 32'h0);
        tick();
        repeat (6) tick();

        // Random back-pressure and random aligned redirects.
        since = 0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (since >= 40 || $urandom_range(0, 24) == 0) begin
                tgt = $urandom();
                tgt[1:0] = 2'b00;
                redirect(tgt);
                since = 0;
            end else begin
                tick();
                since++;
            end
        end

        // Misaligned redirect traps; later redirects ignored; reset recovers.
        out_ready = 1'b0;
        redirect(32'h200);
        repeat (4) tick();
        redirect(32'h42);
        @(negedge clk);
        check("trap_set", 32'(trap), 32'h1);
        check("trap_pc", trap_pc, 32'h42);
        check("trap_valid", 32'(out_valid), 32'h0);
        check("trap_addr_hold", imem_addr, 32'h208);
        tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("trap_sticky", 32'(trap), 32'h1);
        check("trap_pc_sticky", trap_pc, 32'h42);
        check("trap_valid_stays", 32'(out_valid), 32'h0);
        check("trap_addr_ignored", imem_addr, 32'h208);
        tick();
        do_reset(2);
        @(negedge clk);
        check("rst_trap_clear", 32'(trap), 32'h0);
        check("rst_trap_pc_clear", trap_pc, 32'h0);
        check("rst_restart_addr", imem_addr, 32'h0);
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
